// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default framing constants,
// also used by baud_gen and uart_tx.
package uart_pkg;

  localparam int unsigned DefaultOversample = 16;
  localparam int unsigned DefaultDataBits   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rxStateT;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-edge detection, midpoint sampling, LSB-first data.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefaultDataBits,
  parameter int unsigned OVERSAMPLE = DefaultOversample
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxClock,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frameError,
  output logic                 parityError,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] MidTick  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [IdxW-1:0] LastBit  = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);

`ifdef UART_RX_PARITY_EN
  localparam rxStateT AfterData = StParity;
`else
  localparam rxStateT AfterData = StStop;
`endif

  logic                 rxS;
  logic                 rxPrev;
  rxStateT              state;
  logic [CntW-1:0]      tickCnt;
  logic [IdxW-1:0]      bitIdx;
  logic [DATA_BITS-1:0] shiftReg;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) uSync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rxS)
  );

  // Previous synchronized level for the falling-edge detector (runs every clk).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxPrev <= 1'b1;
    end else begin
      rxPrev <= rxS;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parityBit;
  logic parityBad;
  assign parityBad = ((^shiftReg) ^ parityBit) != PARITY_ODD;
`else
  assign parityError = 1'b0;
`endif

  // Frame FSM with registered data, strobes and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      tickCnt    <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frameError <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit   <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      valid      <= 1'b0;
      frameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError <= 1'b0;
`endif
      case (state)
        StIdle: begin
          // A tick coinciding with the edge is dropped: the counter restarts at 0.
          if (rxPrev && !rxS) begin
            tickCnt <= '0;
            state   <= StStart;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (rxClock) begin
            if (tickCnt == MidTick) begin
              if (!rxS) begin
                tickCnt <= '0;
                bitIdx  <= '0;
                state   <= StData;
              end else begin
                // Line went back high before the midpoint: treat as noise.
                state <= StIdle;
                busy  <= 1'b0;
              end
            end else begin
              tickCnt <= tickCnt + CntOne;
            end
          end
        end
        StData: begin
          if (rxClock) begin
            if (tickCnt == LastTick) begin
              tickCnt  <= '0;
              shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
              if (bitIdx == LastBit) begin
                state <= AfterData;
              end else begin
                bitIdx <= bitIdx + IdxOne;
              end
            end else begin
              tickCnt <= tickCnt + CntOne;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (rxClock) begin
            if (tickCnt == LastTick) begin
              tickCnt   <= '0;
              parityBit <= rxS;
              state     <= StStop;
            end else begin
              tickCnt <= tickCnt + CntOne;
            end
          end
        end
`endif
        StStop: begin
          if (rxClock) begin
            if (tickCnt == LastTick) begin
              // Back to idle at the stop midpoint so a following start edge is caught.
              state <= StIdle;
              busy  <= 1'b0;
              if (!rxS) begin
                frameError <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (parityBad) begin
                parityError <= 1'b1;
              end
              if (rxS && !parityBad) begin
                data  <= shiftReg;
                valid <= 1'b1;
              end
`else
              if (rxS) begin
                data  <= shiftReg;
                valid <= 1'b1;
              end
`endif
            end else begin
              tickCnt <= tickCnt + CntOne;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: reset, good frame with timing, bad stop bit,
// start glitch, back-to-back frames, mid-frame reset and (optionally) parity.
module tb_uart_rx;

  localparam int TickDiv = 4;               // clk per rxClock pulse
  localparam int BitClk  = 16 * TickDiv;    // clk per serial bit
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn        = 1'b1;
  localparam int ExpStopTicks = 168;        // ticks 0..167 seen while busy
`else
  localparam bit ParEn        = 1'b0;
  localparam int ExpStopTicks = 152;        // ticks 0..151 seen while busy
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       rxClock = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frameError;
  logic       parityError;
  logic       busy;

  int nVec = 0;
  int nErr = 0;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .rxClock    (rxClock),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frameError (frameError),
    .parityError(parityError),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clk wide every TickDiv clocks.
  logic [1:0] divCnt = 2'd0;
  always @(posedge clk) begin
    divCnt  <= divCnt + 2'd1;
    rxClock <= (divCnt == 2'd3);
  end

  // Ticks seen while busy; counts DUT tick index + 1.
  int ticksSeen = 0;
  always @(posedge clk) begin
    if (!busy) ticksSeen <= 0;
    else if (rxClock) ticksSeen <= ticksSeen + 1;
  end

  // Output monitor, sampled mid-cycle.
  int         validCnt = 0;
  int         ferrCnt = 0;
  int         perrCnt = 0;
  int         busyRise = 0;
  int         busyHighCyc = 0;
  int         overlapCnt = 0;
  int         busyFallTicks = -1;
  int         validTicks = -1;
  logic       busyPrev = 1'b0;
  logic [7:0] capQ[$];
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      validCnt   <= validCnt + 1;
      validTicks <= ticksSeen;
      capQ.push_back(data);
    end
    if (frameError === 1'b1) ferrCnt <= ferrCnt + 1;
    if (parityError === 1'b1) perrCnt <= perrCnt + 1;
    if (busy === 1'b1) busyHighCyc <= busyHighCyc + 1;
    if (busy === 1'b1 && !busyPrev) busyRise <= busyRise + 1;
    if (busy === 1'b0 && busyPrev) busyFallTicks <= ticksSeen;
    if (valid === 1'b1 && busy === 1'b1) overlapCnt <= overlapCnt + 1;
    busyPrev <= (busy === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] value, input bit stopBit, input bit withPar,
                           input bit parBit);
    rx = 1'b0;
    waitClk(BitClk);
    for (int i = 0; i < 8; i++) begin
      rx = value[i];
      waitClk(BitClk);
    end
    if (withPar) begin
      rx = parBit;
      waitClk(BitClk);
    end
    rx = stopBit;
    waitClk(BitClk);
  endtask

  // Frame with correct even parity when parity is built in.
  task automatic sendByte(input logic [7:0] value, input bit stopBit);
    sendFrame(value, stopBit, ParEn, ^value);
  endtask

  task automatic test_reset;
    int v0, f0, p0, b0;
    reset = 1'b1;
    rx    = 1'b1;
    waitClk(5);
    reset = 1'b0;
    @(negedge clk);
    nVec++; if (data !== 8'h00) begin nErr++; $display("FAIL reset_data: got %h want 00", data); end
    nVec++; if (valid !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %b want 0", valid); end
    nVec++; if (frameError !== 1'b0) begin nErr++; $display("FAIL reset_ferr: got %b want 0", frameError); end
    nVec++; if (parityError !== 1'b0) begin nErr++; $display("FAIL reset_perr: got %b want 0", parityError); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", busy); end
    v0 = validCnt; f0 = ferrCnt; p0 = perrCnt; b0 = busyHighCyc;
    waitClk(2000);
    @(negedge clk);
    nVec++; if (validCnt - v0 != 0) begin nErr++; $display("FAIL idle_valid: got %0d pulses want 0", validCnt - v0); end
    nVec++; if (ferrCnt - f0 != 0) begin nErr++; $display("FAIL idle_ferr: got %0d pulses want 0", ferrCnt - f0); end
    nVec++; if (perrCnt - p0 != 0) begin nErr++; $display("FAIL idle_perr: got %0d pulses want 0", perrCnt - p0); end
    nVec++; if (busyHighCyc - b0 != 0) begin nErr++; $display("FAIL idle_busy: got %0d busy cycles want 0", busyHighCyc - b0); end
  endtask

  task automatic test_good_frame;
    int v0, f0;
    v0 = validCnt; f0 = ferrCnt;
    sendByte(8'hA5, 1'b1);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (validCnt - v0 != 1) begin nErr++; $display("FAIL good_valid_cnt: got %0d want 1", validCnt - v0); end
    nVec++; if (data !== 8'hA5) begin nErr++; $display("FAIL good_data: got %h want a5", data); end
    nVec++; if (capQ.size() < 1 || capQ[capQ.size()-1] !== 8'hA5) begin
      nErr++; $display("FAIL good_captured: got %0d entries want last a5", capQ.size()); end
    nVec++; if (ferrCnt - f0 != 0) begin nErr++; $display("FAIL good_ferr: got %0d want 0", ferrCnt - f0); end
    nVec++; if (validTicks != ExpStopTicks) begin
      nErr++; $display("FAIL good_timing: got %0d ticks want %0d", validTicks, ExpStopTicks); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL good_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_bad_stop;
    int v0, f0;
    sendByte(8'h11, 1'b1);
    rx = 1'b1;
    waitClk(50);
    v0 = validCnt; f0 = ferrCnt;
    sendByte(8'h3C, 1'b0);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (ferrCnt - f0 != 1) begin nErr++; $display("FAIL badstop_ferr: got %0d want 1", ferrCnt - f0); end
    nVec++; if (validCnt - v0 != 0) begin nErr++; $display("FAIL badstop_valid: got %0d want 0", validCnt - v0); end
    nVec++; if (data !== 8'h11) begin nErr++; $display("FAIL badstop_data: got %h want 11", data); end
  endtask

  task automatic test_glitch;
    int v0, f0, r0;
    v0 = validCnt; f0 = ferrCnt; r0 = busyRise;
    rx = 1'b0;
    waitClk(4 * TickDiv);
    rx = 1'b1;
    waitClk(200);
    @(negedge clk);
    nVec++; if (busyRise - r0 != 1) begin nErr++; $display("FAIL glitch_busy_rise: got %0d want 1", busyRise - r0); end
    nVec++; if (busyFallTicks != 8) begin nErr++; $display("FAIL glitch_busy_fall: got %0d ticks want 8", busyFallTicks); end
    nVec++; if (validCnt - v0 != 0) begin nErr++; $display("FAIL glitch_valid: got %0d want 0", validCnt - v0); end
    nVec++; if (ferrCnt - f0 != 0) begin nErr++; $display("FAIL glitch_ferr: got %0d want 0", ferrCnt - f0); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0, q0, f0;
    v0 = validCnt; q0 = capQ.size(); f0 = ferrCnt;
    sendByte(8'h00, 1'b1);
    sendByte(8'hFF, 1'b1);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (validCnt - v0 != 2) begin nErr++; $display("FAIL b2b_valid_cnt: got %0d want 2", validCnt - v0); end
    nVec++; if (capQ.size() < q0 + 2 || capQ[q0] !== 8'h00) begin
      nErr++; $display("FAIL b2b_first: got %0d entries want first 00", capQ.size() - q0); end
    nVec++; if (capQ.size() < q0 + 2 || capQ[q0+1] !== 8'hFF) begin
      nErr++; $display("FAIL b2b_second: got %0d entries want second ff", capQ.size() - q0); end
    nVec++; if (overlapCnt != 0) begin nErr++; $display("FAIL valid_busy_overlap: got %0d want 0", overlapCnt); end
    // Third frame aborted by reset in the middle of its data bits.
    @(posedge clk);
    rx = 1'b0; waitClk(BitClk);
    rx = 1'b1; waitClk(BitClk);
    rx = 1'b0; waitClk(BitClk / 2);
    reset = 1'b1;
    waitClk(3);
    @(negedge clk);
    nVec++; if (data !== 8'h00) begin nErr++; $display("FAIL midreset_data: got %h want 00", data); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL midreset_busy: got %b want 0", busy); end
    nVec++; if (valid !== 1'b0 || frameError !== 1'b0) begin
      nErr++; $display("FAIL midreset_strobes: got valid %b ferr %b want 0 0", valid, frameError); end
    v0 = validCnt; f0 = ferrCnt;
    rx = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    waitClk(300);
    sendByte(8'h81, 1'b1);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (validCnt - v0 != 1) begin nErr++; $display("FAIL after_reset_valid: got %0d want 1", validCnt - v0); end
    nVec++; if (data !== 8'h81) begin nErr++; $display("FAIL after_reset_data: got %h want 81", data); end
    nVec++; if (ferrCnt - f0 != 0) begin nErr++; $display("FAIL after_reset_ferr: got %0d want 0", ferrCnt - f0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = validCnt; p0 = perrCnt;
    sendFrame(8'h07, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (perrCnt - p0 != 1) begin nErr++; $display("FAIL parity_bad_perr: got %0d want 1", perrCnt - p0); end
    nVec++; if (validCnt - v0 != 0) begin nErr++; $display("FAIL parity_bad_valid: got %0d want 0", validCnt - v0); end
    v0 = validCnt; p0 = perrCnt;
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1);
    rx = 1'b1;
    waitClk(100);
    @(negedge clk);
    nVec++; if (perrCnt - p0 != 0) begin nErr++; $display("FAIL parity_good_perr: got %0d want 0", perrCnt - p0); end
    nVec++; if (validCnt - v0 != 1) begin nErr++; $display("FAIL parity_good_valid: got %0d want 1", validCnt - v0); end
    nVec++; if (data !== 8'h07) begin nErr++; $display("FAIL parity_good_data: got %h want 07", data); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_glitch();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
